// File: rtl/tx_queue_pkg.sv
// rtl/tx_queue_pkg.sv - shared state encodings and FIFO word layout for tx_queue
package tx_queue_pkg;

    localparam int DATA_W   = 64;
    localparam int STRB_W   = 8;
    localparam int FIFO_W   = 73;
    localparam int LAST_BIT = 72;
    localparam int STRB_MSB = 71;
    localparam int STRB_LSB = 64;
    localparam int DATA_MSB = 63;

    typedef enum logic {
        W_ACCEPT = 1'b0,
        W_DROP   = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_SEND  = 2'd2,
        R_GAP   = 2'd3
    } rd_state_t;

    function automatic logic [FIFO_W-1:0] pack_word(
        input logic              last,
        input logic [STRB_W-1:0] strb,
        input logic [DATA_W-1:0] data
    );
        return {last, strb, data};
    endfunction

endpackage

// File: rtl/tx_pkt_fifo.sv
// rtl/tx_pkt_fifo.sv - packet FIFO with speculative write, commit/rewind and registered read
module tx_pkt_fifo
    import tx_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [FIFO_W-1:0] wr_word,
    input  logic              wr_commit,
    input  logic              wr_rewind,
    input  logic              rd_en,
    output logic [FIFO_W-1:0] rd_word,
    output logic              full,
    output logic              full_after_write,
    output logic              pkt_avail
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [FIFO_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     commit_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_inc;

    assign wr_ptr_inc = wr_ptr + ONE;

    // Occupancy uses the registered read pointer, so full is pessimistic by one cycle.
    assign full             = (wr_ptr - rd_ptr) == DEPTH;
    assign full_after_write = (wr_ptr_inc - rd_ptr) == DEPTH;

    // Only words behind commit_ptr belong to whole packets and are visible to the reader.
    assign pkt_avail = commit_ptr != rd_ptr;

    // RAM write port; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
        end
    end

    // Registered read port; it also serves as the MAC data register in the top level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_word <= '0;
        end else if (rd_en) begin
            rd_word <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    // Pointer update: rewind overrides the speculative increment, commit marks a packet end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            if (wr_rewind) begin
                wr_ptr <= commit_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (wr_en && wr_commit) begin
                commit_ptr <= wr_ptr_inc;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

endmodule

// File: rtl/tx_queue.sv
// rtl/tx_queue.sv - store-and-forward AXI-Stream to 10G MAC TX converter
module tx_queue
    import tx_queue_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 9
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [AXI_DATA_WIDTH-1:0]   tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] tstrb,
    input  logic                        tvalid,
    input  logic                        tlast,
    output logic                        tready,
    output logic [AXI_DATA_WIDTH-1:0]   tx_data,
    output logic [AXI_DATA_WIDTH/8-1:0] tx_data_valid,
    output logic                        tx_start,
    input  logic                        tx_ack,
    output logic                        tx_underrun,
    output logic                        drop_pulse
);

    wr_state_t w_state, w_state_nxt;
    rd_state_t r_state, r_state_nxt;

    logic              wr_en, wr_commit, wr_rewind, drop_nxt;
    logic              rd_en, start_nxt, underrun_nxt;
    logic [STRB_W-1:0] strb_stored;
    logic [FIFO_W-1:0] wr_word;
    logic [FIFO_W-1:0] fifo_rd_word;
    logic              fifo_full, fifo_full_after_write, pkt_avail;
    logic              word_last;

    // Middle beats always carry a full word, so their qualifiers are stored as all ones.
    assign strb_stored = tlast ? tstrb : 8'hFF;
    assign wr_word     = pack_word(tlast, strb_stored, tdata);

    tx_pkt_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk              (clk),
        .reset_n          (reset_n),
        .wr_en            (wr_en),
        .wr_word          (wr_word),
        .wr_commit        (wr_commit),
        .wr_rewind        (wr_rewind),
        .rd_en            (rd_en),
        .rd_word          (fifo_rd_word),
        .full             (fifo_full),
        .full_after_write (fifo_full_after_write),
        .pkt_avail        (pkt_avail)
    );

    // Write FSM state and the registered drop indication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state    <= W_ACCEPT;
            drop_pulse <= 1'b0;
        end else begin
            w_state    <= w_state_nxt;
            drop_pulse <= drop_nxt;
        end
    end

    // Write FSM: store beats speculatively, commit on a good tlast, rewind on a bad one or overflow.
    always_comb begin
        w_state_nxt = w_state;
        tready      = 1'b1;
        wr_en       = 1'b0;
        wr_commit   = 1'b0;
        wr_rewind   = 1'b0;
        drop_nxt    = 1'b0;
        case (w_state)
            W_ACCEPT: begin
                tready = ~fifo_full;
                if (tvalid && !fifo_full) begin
                    wr_en = 1'b1;
                    if (tlast) begin
                        if (tstrb != '0) begin
                            wr_commit = 1'b1;
                        end else begin
                            wr_rewind = 1'b1;
                            drop_nxt  = 1'b1;
                        end
                    end else if (fifo_full_after_write) begin
                        // The packet cannot finish in the space left; discard the rest of it.
                        w_state_nxt = W_DROP;
                    end
                end
            end
            W_DROP: begin
                wr_rewind = 1'b1;
                if (tvalid && tlast) begin
                    drop_nxt    = 1'b1;
                    w_state_nxt = W_ACCEPT;
                end
            end
            default: w_state_nxt = W_ACCEPT;
        endcase
    end

    assign word_last = fifo_rd_word[LAST_BIT];

    // Read FSM state plus the start and underrun pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= R_IDLE;
            tx_start    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            r_state     <= r_state_nxt;
            tx_start    <= start_nxt;
            tx_underrun <= underrun_nxt;
        end
    end

    // Read FSM: prefetch the first word, hold it for tx_ack, then stream one word per cycle.
    always_comb begin
        r_state_nxt  = r_state;
        rd_en        = 1'b0;
        start_nxt    = 1'b0;
        underrun_nxt = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (pkt_avail) begin
                    rd_en       = 1'b1;
                    start_nxt   = 1'b1;
                    r_state_nxt = R_START;
                end
            end
            R_START: begin
                if (tx_ack) begin
                    if (word_last) begin
                        r_state_nxt = R_GAP;
                    end else if (pkt_avail) begin
                        rd_en       = 1'b1;
                        r_state_nxt = R_SEND;
                    end else begin
                        underrun_nxt = 1'b1;
                        r_state_nxt  = R_GAP;
                    end
                end
            end
            R_SEND: begin
                if (word_last) begin
                    r_state_nxt = R_GAP;
                end else if (pkt_avail) begin
                    rd_en = 1'b1;
                end else begin
                    underrun_nxt = 1'b1;
                    r_state_nxt  = R_GAP;
                end
            end
            R_GAP: begin
                // The bubble cycle also performs the idle check so queued frames keep a single-cycle gap.
                if (pkt_avail) begin
                    rd_en       = 1'b1;
                    start_nxt   = 1'b1;
                    r_state_nxt = R_START;
                end else begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Byte valids follow the read state, so an asynchronous reset clears them at once.
    assign tx_data       = fifo_rd_word[DATA_MSB:0];
    assign tx_data_valid = (r_state == R_START || r_state == R_SEND) ?
                           fifo_rd_word[STRB_MSB:STRB_LSB] : '0;

endmodule

// File: tb/tb_tx_queue.sv
// tb/tb_tx_queue.sv - directed self-checking bench for tx_queue
module tb_tx_queue;

    localparam int AW = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] tdata   = '0;
    logic [7:0]  tstrb   = '0;
    logic        tvalid  = 1'b0;
    logic        tlast   = 1'b0;
    logic        tready;
    logic [63:0] tx_data;
    logic [7:0]  tx_data_valid;
    logic        tx_start;
    logic        tx_ack  = 1'b0;
    logic        tx_underrun;
    logic        drop_pulse;

    tx_queue #(
        .AXI_DATA_WIDTH (64),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tdata         (tdata),
        .tstrb         (tstrb),
        .tvalid        (tvalid),
        .tlast         (tlast),
        .tready        (tready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_start      (tx_start),
        .tx_ack        (tx_ack),
        .tx_underrun   (tx_underrun),
        .drop_pulse    (drop_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // MAC model state
    logic [71:0] got_q[$];
    logic [71:0] exp_q[$];
    bit in_frame = 1'b0;
    bit acked    = 1'b0;
    int ack_delay = 0;
    int since = 0, hold = 0, starts = 0, drops = 0, underruns = 0;
    int gap_run = 0, last_gap = 0, start_cyc = 0, last_cyc = 0, stalls = 0;

    // MAC model: acks the first word after ack_delay cycles and collects consumed words.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame = 1'b0;
            acked    = 1'b0;
            tx_ack   = 1'b0;
        end else begin
            if (drop_pulse)  drops++;
            if (tx_underrun) underruns++;
            if (tx_start) begin
                starts++;
                in_frame  = 1'b1;
                acked     = 1'b0;
                hold      = 0;
                since     = 0;
                last_gap  = gap_run;
                start_cyc = cyc;
            end
            tx_ack = in_frame && !acked && (since == ack_delay);
            if (in_frame) begin
                if (tx_data_valid != '0) begin
                    if (acked || tx_ack) got_q.push_back({tx_data_valid, tx_data});
                    else hold++;
                    if (tx_ack) acked = 1'b1;
                end else if (acked) begin
                    in_frame = 1'b0;
                    gap_run  = 0;
                end
                since++;
            end
            if (!in_frame && tx_data_valid == '0 && !tx_start) gap_run++;
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
        int waits;
        waits = 0;
        @(negedge clk);
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        tvalid = 1'b1;
        while (!tready && waits < 500) begin
            waits++;
            stalls++;
            @(negedge clk);
        end
        if (waits >= 500) chk("tready_timeout", 72'(waits), 72'(0));
        if (l) last_cyc = cyc;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [63:0] base, input logic [7:0] last_strb,
                            input bit expect_tx);
        logic [63:0] d;
        logic [7:0]  s;
        for (int i = 0; i < n; i++) begin
            d = base + 64'(i);
            s = (i == n - 1) ? last_strb : 8'hFF;
            send_beat(d, s, i == n - 1);
            if (expect_tx) exp_q.push_back({s, d});
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((got_q.size() < exp_q.size() || in_frame) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) chk("drain_timeout", 72'(n), 72'(0));
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_words(input string tag);
        chk({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, d0, n;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tready",   72'(tready),        72'(1));
        chk("rst_valid",    72'(tx_data_valid), 72'(0));
        chk("rst_start",    72'(tx_start),      72'(0));
        chk("rst_data",     72'(tx_data),       72'(0));
        chk("rst_underrun", 72'(tx_underrun),   72'(0));
        chk("rst_drop",     72'(drop_pulse),    72'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // 8-beat packet, tx_ack three cycles after tx_start
        ack_delay = 3;
        s0 = starts;
        send_pkt(8, 64'hA0A0_0000_0000_0000, 8'hFF, 1'b1);
        drain(200);
        chk("p8_starts",  72'(starts - s0),         72'(1));
        chk("p8_hold",    72'(hold),                72'(3));
        chk("p8_latency", 72'(start_cyc - last_cyc), 72'(2));
        compare_words("p8");

        // single-beat packet with partial qualifiers
        ack_delay = 0;
        s0 = starts;
        send_beat(64'h1122334455667788, 8'h0F, 1'b1);
        exp_q.push_back({8'h0F, 64'h1122334455667788});
        drain(200);
        chk("p1_starts", 72'(starts - s0),   72'(1));
        chk("p1_ended",  72'(in_frame),      72'(0));
        chk("p1_idle",   72'(tx_data_valid), 72'(0));
        compare_words("p1");

        // two 4-beat packets back to back, immediate ack
        s0 = starts;
        send_pkt(4, 64'hB100_0000_0000_0010, 8'hFF, 1'b1);
        send_pkt(4, 64'hB200_0000_0000_0020, 8'h07, 1'b1);
        drain(200);
        chk("b2b_starts", 72'(starts - s0), 72'(2));
        chk("b2b_gap",    72'(last_gap),    72'(1));
        compare_words("b2b");

        // oversize packet dropped, following packet intact
        s0 = starts;
        d0 = drops;
        stalls = 0;
        send_pkt(20, 64'hC000_0000_0000_0000, 8'hFF, 1'b0);
        send_pkt(3,  64'hD000_0000_0000_0100, 8'h3F, 1'b1);
        drain(200);
        chk("ovr_stalls", 72'(stalls),       72'(0));
        chk("ovr_drops",  72'(drops - d0),   72'(1));
        chk("ovr_starts", 72'(starts - s0),  72'(1));
        compare_words("ovr");

        // tlast with empty qualifiers is dropped
        s0 = starts;
        d0 = drops;
        send_pkt(3, 64'hE000_0000_0000_0000, 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        chk("zs_drops",  72'(drops - d0),    72'(1));
        chk("zs_starts", 72'(starts - s0),   72'(0));
        chk("zs_words",  72'(got_q.size()),  72'(0));

        // reset in the middle of a frame
        send_pkt(8, 64'hF000_0000_0000_0000, 8'hFF, 1'b0);
        n = 0;
        while (got_q.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("midrst_wait_timeout", 72'(n), 72'(0));
        chk("pre_rst_active", 72'(tx_data_valid != '0), 72'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid",  72'(tx_data_valid), 72'(0));
        chk("midrst_tready", 72'(tready),        72'(1));
        chk("midrst_start",  72'(tx_start),      72'(0));
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("post_rst_tready", 72'(tready), 72'(1));
        s0 = starts;
        send_pkt(2, 64'h5A5A_0000_0000_0000, 8'h01, 1'b1);
        drain(200);
        chk("post_rst_starts", 72'(starts - s0), 72'(1));
        compare_words("post_rst");

        chk("underrun_never", 72'(underruns), 72'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
